// File: rtl/seg7_capture_if.sv
// Bus bundle between the multiplexed 7-segment display lines and the
// capture block. The display side (master) drives the active-low select
// and segment lines; the capture side (slave) returns the decoded word,
// status pulses and a debug view of its frame state machine.
//
// Handshake semantics: there is no valid/ready flow control on this bus.
// tubeSelect/tubeDisplay are free-running levels. dataValid, frameDone and
// segError are single-cycle pulses, qualified by nothing else.
// dataOut and errCount are levels that hold between updates.
interface seg7_capture_if;
  logic [7:0]  tubeSelect;
  logic [7:0]  tubeDisplay;
  logic [31:0] dataOut;
  logic        dataValid;
  logic        frameDone;
  logic        segError;
  logic [7:0]  errCount;
  logic        locked;
  logic [1:0]  frame_state;

  modport master (
    output tubeSelect, tubeDisplay,
    input  dataOut, dataValid, frameDone, segError, errCount, locked, frame_state
  );

  modport slave (
    input  tubeSelect, tubeDisplay,
    output dataOut, dataValid, frameDone, segError, errCount, locked, frame_state
  );
endinterface

// File: rtl/seg7_capture.sv
// Seven-segment scan decoder. It samples the active-low digit-select and
// segment lines of an 8-digit multiplexed hex display and decodes each
// settled digit back to a nibble. It publishes the 32-bit word once that
// word has been seen in STABLE_FRAMES consecutive identical complete frames.
module seg7_capture #(
  parameter int SETTLE        = 4,
  parameter int STABLE_FRAMES = 2
) (
  input logic          CLK,
  input logic          RST,
  seg7_capture_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    COMPLETE = 2'd2
  } frame_state_t;

  logic [7:0]   sel_m, sel_s, sel_q;
  logic [7:0]   disp_m, disp_s, disp_q;
  logic [3:0]   settle_cnt;
  logic [7:0]   bitmap, bitmap_nx;
  logic [31:0]  frame, frame_nx;
  logic [31:0]  last_frame;
  logic [31:0]  data_out;
  logic [2:0]   match_cnt, match_nx;
  logic         data_valid, frame_done, seg_error, locked_q;
  logic [7:0]   err_count;
  frame_state_t state, state_nx;

  logic         changed, strobe, sel_single, cap_ok, cap_err, full, publish;
  logic [7:0]   sel_n;
  logic [2:0]   digit_idx;
  logic [4:0]   dec;

  // Active-low segment pattern (dp excluded) to {ok, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h40: decode = 5'h10;
      7'h79: decode = 5'h11;
      7'h24: decode = 5'h12;
      7'h30: decode = 5'h13;
      7'h19: decode = 5'h14;
      7'h12: decode = 5'h15;
      7'h02: decode = 5'h16;
      7'h78: decode = 5'h17;
      7'h00: decode = 5'h18;
      7'h10: decode = 5'h19;
      7'h08: decode = 5'h1A;
      7'h03: decode = 5'h1B;
      7'h46: decode = 5'h1C;
      7'h21: decode = 5'h1D;
      7'h06: decode = 5'h1E;
      7'h0E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // Two-flop synchronizers plus a one-cycle-delayed copy for change detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel_m  <= 8'hFF;
      sel_s  <= 8'hFF;
      sel_q  <= 8'hFF;
      disp_m <= 8'hFF;
      disp_s <= 8'hFF;
      disp_q <= 8'hFF;
    end else begin
      sel_m  <= bus.tubeSelect;
      sel_s  <= sel_m;
      sel_q  <= sel_s;
      disp_m <= bus.tubeDisplay;
      disp_s <= disp_m;
      disp_q <= disp_s;
    end
  end

  // Settle counter restarts on any change and saturates at SETTLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      settle_cnt <= 4'd0;
    else if (changed)
      settle_cnt <= 4'd0;
    else if (settle_cnt != 4'(SETTLE))
      settle_cnt <= settle_cnt + 4'd1;
  end

  // Capture qualification: the strobe fires once per dwell, as the counter
  // reaches SETTLE. Only a single low select bit makes it a real capture.
  always_comb begin
    changed    = (sel_s != sel_q) || (disp_s != disp_q);
    strobe     = !changed && (settle_cnt == 4'(SETTLE - 1));
    sel_n      = ~sel_s;
    sel_single = (sel_n != 8'd0) && ((sel_n & (sel_n - 8'd1)) == 8'd0);
    digit_idx  = 3'd0;
    for (int i = 0; i < 8; i++)
      if (sel_n[i]) digit_idx = 3'(i);
    dec     = decode(disp_s[6:0]);
    cap_ok  = strobe && sel_single && dec[4];
    cap_err = strobe && sel_single && !dec[4];
  end

  // Frame next-state: bitmap/frame update, completion, match and publish.
  // Completion is detected on the incoming bitmap, so the frame-done actions
  // land on the edge that ends the COMPLETE cycle's predecessor. The bitmap
  // is therefore already clear for any capture during COMPLETE.
  always_comb begin
    bitmap_nx = bitmap;
    frame_nx  = frame;
    state_nx  = state;
    match_nx  = match_cnt;
    if (cap_err) begin
      bitmap_nx = 8'd0;
    end else if (cap_ok) begin
      bitmap_nx[digit_idx]              = 1'b1;
      frame_nx[{digit_idx, 2'b00} +: 4] = dec[3:0];
    end
    full = (bitmap_nx == 8'hFF);
    if (frame_nx == last_frame)
      match_nx = (match_cnt == 3'(STABLE_FRAMES)) ? match_cnt : match_cnt + 3'd1;
    else
      match_nx = 3'd1;
    publish = full && (match_nx == 3'(STABLE_FRAMES)) &&
              (!locked_q || (frame_nx != data_out));
    case (state)
      EMPTY:    if (cap_ok) state_nx = FILLING;
      FILLING:  if (cap_err) state_nx = EMPTY;
                else if (full) state_nx = COMPLETE;
      COMPLETE: state_nx = cap_ok ? FILLING : EMPTY;
      default:  state_nx = EMPTY;
    endcase
  end

  // Frame state register and all registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= EMPTY;
      bitmap     <= 8'd0;
      frame      <= 32'd0;
      last_frame <= 32'd0;
      match_cnt  <= 3'd0;
      data_out   <= 32'd0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      seg_error  <= 1'b0;
      err_count  <= 8'd0;
      locked_q   <= 1'b0;
    end else begin
      state      <= state_nx;
      bitmap     <= full ? 8'd0 : bitmap_nx;
      frame      <= frame_nx;
      frame_done <= full;
      data_valid <= publish;
      seg_error  <= cap_err;
      if (cap_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      if (full) begin
        last_frame <= frame_nx;
        match_cnt  <= match_nx;
      end
      if (publish) begin
        data_out <= frame_nx;
        locked_q <= 1'b1;
      end
    end
  end

  assign bus.dataOut     = data_out;
  assign bus.dataValid   = data_valid;
  assign bus.frameDone   = frame_done;
  assign bus.segError    = seg_error;
  assign bus.errCount    = err_count;
  assign bus.locked      = locked_q;
  assign bus.frame_state = state;

endmodule
